main_mem_arbiter: RTL and testbench

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

---
 rtl/main_mem_arbiter_pkg.sv | 22 ++
 rtl/address_map.vh | 11 +
 rtl/main_mem_arbiter_rr_arbiter2.sv | 24 ++
 rtl/main_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// rtl/main_mem_arbiter_pkg.sv - FSM encodings and reset constants for main_mem_arbiter
//
// Purpose: shared types for the two-requester main memory arbiter.
// Ports: none (package).
package main_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC  = 2'd1;
  localparam logic [1:0] ST_CAPTURE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_ACCESS  = ST_ACCESS_ENC,
    ST_CAPTURE = ST_CAPTURE_ENC,
    ST_DONE    = ST_DONE_ENC
  } state_e;

  // "Last granted = 1" out of reset so requester 0 wins the first contest.
  localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/address_map.vh
// rtl/address_map.vh - shared bus widths and register addresses for the main memory
`ifndef ADDRESS_MAP_VH
`define ADDRESS_MAP_VH

`define ADDR_WIDTH      8
`define DATA_WIDTH      8

`define CH_MUX_ENABLE   8'h10
`define CH_MUX_SELECTOR 8'h11

`endif

// File: rtl/main_mem_arbiter_rr_arbiter2.sv
// rtl/main_mem_arbiter_rr_arbiter2.sv - two-way round-robin winner select
//
// Purpose: combinational winner selection between two requesters.
// Ports:
//   i_req0, i_req1 : request lines
//   i_last         : index of the requester granted last
//   o_gnt          : index of the winner (meaningful only when a request is high)
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_gnt
);

  always_comb begin
    o_gnt = 1'b0;
    if (i_req0 && i_req1) begin
      o_gnt = ~i_last;
    end else if (i_req1) begin
      o_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// rtl/main_mem_arbiter.sv - two-requester round-robin arbiter for the main memory bus
//
// Purpose: serialises single accesses from two requesters onto one main
// memory bus; one transaction outstanding at a time.
// Ports:
//   i_clk, i_rst                     : clock, asynchronous active-low reset
//   i_req*/i_wr*/i_addr*/i_wdata*    : requester 0/1 access (held until ack)
//   o_ack*                           : one-cycle completion pulse
//   o_rdata*                         : per-requester read data, held until next read
//   o_mem_addr/o_mem_data/o_mem_wr   : memory bus, idle values outside ACCESS
//   i_mem_data                       : memory read data, one cycle after address
//   o_busy                           : high whenever the FSM is not IDLE
`include "address_map.vh"

module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int                 ADDR_W    = `ADDR_WIDTH,
  parameter int                 DATA_W    = `DATA_WIDTH,
  parameter logic [ADDR_W-1:0]  IDLE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wr0,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wr_q, mem_wr_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                gnt;

  rr_arbiter2 u_rr (
    .i_req0 (i_req0),
    .i_req1 (i_req1),
    .i_last (last_q),
    .o_gnt  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    busy_d     = busy_q;
    // Bus and acks fall back to idle every cycle unless a state drives them.
    mem_addr_d = IDLE_ADDR;
    mem_data_d = '0;
    mem_wr_d   = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          idx_d      = gnt;
          wr_d       = gnt ? i_wr1 : i_wr0;
          // The bus registers double as the latched address/data, so they
          // are loaded here and present exactly during the ACCESS cycle.
          mem_addr_d = gnt ? i_addr1  : i_addr0;
          mem_data_d = gnt ? i_wdata1 : i_wdata0;
          mem_wr_d   = gnt ? i_wr1    : i_wr0;
          busy_d     = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wr_q) begin
          ack0_d  = ~idx_q;
          ack1_d  = idx_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (idx_q) begin
          rdata1_d = i_mem_data;
        end else begin
          rdata0_d = i_mem_data;
        end
        ack0_d  = ~idx_q;
        ack1_d  = idx_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Requests are ignored here; the ack pulse is live this cycle.
        last_d  = idx_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RESET;
      idx_q      <= 1'b0;
      wr_q       <= 1'b0;
      mem_addr_q <= IDLE_ADDR;
      mem_data_q <= '0;
      mem_wr_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_q   <= mem_wr_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_rdata0   = rdata0_q;
  assign o_rdata1   = rdata1_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_wr   = mem_wr_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb/tb_main_mem_arbiter.sv - self-checking bench for main_mem_arbiter
module tb_main_mem_arbiter;

  localparam int         AW         = 8;
  localparam int         DW         = 8;
  localparam logic [7:0] IDLE_A     = 8'hFF;
  localparam logic [7:0] A_EN       = 8'h10;
  localparam logic [7:0] A_SEL      = 8'h11;
  localparam logic [7:0] A_UNMAPPED = 8'h7F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req0 = 1'b0, i_req1 = 1'b0;
  logic          i_wr0 = 1'b0, i_wr1 = 1'b0;
  logic [AW-1:0] i_addr0 = '0, i_addr1 = '0;
  logic [DW-1:0] i_wdata0 = '0, i_wdata1 = '0;
  logic          o_ack0, o_ack1;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_wr;
  logic [DW-1:0] mem_rdata = '0;
  logic          o_busy;

  main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IDLE_ADDR(IDLE_A)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_wr0      (i_wr0),
    .i_wr1      (i_wr1),
    .i_addr0    (i_addr0),
    .i_addr1    (i_addr1),
    .i_wdata0   (i_wdata0),
    .i_wdata1   (i_wdata1),
    .o_ack0     (o_ack0),
    .o_ack1     (o_ack1),
    .o_rdata0   (o_rdata0),
    .o_rdata1   (o_rdata1),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_wr   (o_mem_wr),
    .i_mem_data (mem_rdata),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main memory model: two mapped registers, registered read data.
  logic [3:0] ch_ena = 4'h0;
  logic [7:0] ch_sel = 8'h00;
  always @(posedge clk) begin
    if (o_mem_wr) begin
      if (o_mem_addr == A_EN)  ch_ena <= o_mem_data[3:0];
      if (o_mem_addr == A_SEL) ch_sel <= o_mem_data;
    end
    if (o_mem_addr == A_EN)       mem_rdata <= {4'h0, ch_ena};
    else if (o_mem_addr == A_SEL) mem_rdata <= ch_sel;
    else                          mem_rdata <= 8'h00;
  end

  typedef struct {
    int         idx;
    bit         rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   ack_cnt = 0;
  int   wr_cycles = 0;
  int   mon_idx;

  // Scoreboard monitor: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (o_mem_wr) wr_cycles++;
    if (o_ack0 || o_ack1) begin
      ack_cnt++;
      checks++;
      if (o_ack0 && o_ack1) begin
        errors++;
        $display("FAIL dual_ack: ack0=%b ack1=%b, required at most one", o_ack0, o_ack1);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack0=%b ack1=%b at cycle %0d, required none", o_ack0, o_ack1, cyc);
      end else begin
        mon_e   = sb.pop_front();
        mon_idx = o_ack1 ? 1 : 0;
        if (mon_idx !== mon_e.idx) begin
          errors++;
          $display("FAIL ack_order: got ack from %0d, required %0d", mon_idx, mon_e.idx);
        end
        if (mon_e.rd) begin
          checks++;
          if ((mon_idx == 1 ? o_rdata1 : o_rdata0) !== mon_e.rdata) begin
            errors++;
            $display("FAIL rdata%0d: got %02h, required %02h", mon_idx,
                     (mon_idx == 1 ? o_rdata1 : o_rdata0), mon_e.rdata);
          end
        end
      end
    end
  end

  task automatic do_txn(input int idx, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata_exp);
    int sample_cyc;
    int lat;
    int n;
    bit seen;
    @(negedge clk);
    if (idx == 0) begin
      i_req0 = 1'b1; i_wr0 = wr; i_addr0 = addr; i_wdata0 = wdata;
    end else begin
      i_req1 = 1'b1; i_wr1 = wr; i_addr1 = addr; i_wdata1 = wdata;
    end
    sb.push_back('{idx: idx, rd: !wr, rdata: rdata_exp});
    wr_cycles  = 0;
    sample_cyc = cyc + 1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      #1;
      if ((idx == 0 && o_ack0) || (idx == 1 && o_ack1)) seen = 1'b1;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout%0d: no ack after %0d cycles, required ack", idx, n);
    end else begin
      // The ack cycle ends on the next edge; latency counts to that edge.
      lat = cyc - sample_cyc + 1;
      checks++;
      if (lat !== (wr ? 2 : 3)) begin
        errors++;
        $display("FAIL latency%0d: got %0d cycles, required %0d", idx, lat, wr ? 2 : 3);
      end
    end
    if (idx == 0) i_req0 = 1'b0; else i_req1 = 1'b0;
    checks++;
    if (wr_cycles !== (wr ? 1 : 0)) begin
      errors++;
      $display("FAIL mem_wr_cycles: got %0d, required %0d", wr_cycles, wr ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_ack0, o_ack1, o_mem_wr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/ack0/ack1/wr=%b, required 0000", {o_busy, o_ack0, o_ack1, o_mem_wr});
    end
    checks++;
    if ({o_rdata0, o_rdata1} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %04h, required 0000", {o_rdata0, o_rdata1});
    end
    checks++;
    if (o_mem_addr !== IDLE_A || o_mem_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: addr=%02h data=%02h, required %02h 00", o_mem_addr, o_mem_data, IDLE_A);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, A_EN, 8'h05, 8'h00);
    checks++;
    if (ch_ena !== 4'h5) begin
      errors++;
      $display("FAIL ch_ena: got %h, required 5", ch_ena);
    end
    do_txn(0, 1'b0, A_EN, 8'h00, 8'h05);
    do_txn(1, 1'b1, A_SEL, 8'h0A, 8'h00);
    do_txn(1, 1'b0, A_SEL, 8'h00, 8'h0A);
    @(negedge clk);
    checks++;
    if (o_rdata1 !== 8'h0A || o_rdata0 !== 8'h05) begin
      errors++;
      $display("FAIL rdata_hold: got %02h/%02h, required 05/0a", o_rdata0, o_rdata1);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", o_busy);
    end
  endtask

  task automatic test_unmapped();
    do_txn(1, 1'b0, A_UNMAPPED, 8'h00, 8'h00);
    checks++;
    if (o_rdata0 !== 8'h05) begin
      errors++;
      $display("FAIL rdata0_hold: got %02h, required 05", o_rdata0);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back('{idx: k % 2, rd: 1'b0, rdata: 8'h00});
    base = ack_cnt;
    i_req0 = 1'b1; i_wr0 = 1'b1; i_addr0 = A_EN;  i_wdata0 = 8'h03;
    i_req1 = 1'b1; i_wr1 = 1'b1; i_addr1 = A_SEL; i_wdata1 = 8'h44;
    n = 0;
    while ((ack_cnt - base) < 4 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    checks++;
    if ((ack_cnt - base) !== 4 || sb.size() !== 0) begin
      errors++;
      $display("FAIL rr_acks: got %0d acks, %0d pending, required 4 and 0", ack_cnt - base, sb.size());
    end
    checks++;
    if (ch_ena !== 4'h3 || ch_sel !== 8'h44) begin
      errors++;
      $display("FAIL rr_mem: got %h/%02h, required 3/44", ch_ena, ch_sel);
    end
  endtask

  task automatic test_reset_mid_capture();
    int base;
    int n;
    // Reload rdata0 so the reset clear is observable.
    do_txn(0, 1'b0, A_EN, 8'h00, 8'h03);
    @(negedge clk);
    i_req0 = 1'b1; i_wr0 = 1'b0; i_addr0 = A_EN;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL capture_busy: got %b, required 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_ack0, o_mem_wr} !== 3'b000 || o_rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL abort: busy/ack0/wr=%b rdata0=%02h, required 000 00", {o_busy, o_ack0, o_mem_wr}, o_rdata0);
    end
    i_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb.push_back('{idx: 0, rd: 1'b0, rdata: 8'h00});
    sb.push_back('{idx: 1, rd: 1'b0, rdata: 8'h00});
    base = ack_cnt;
    i_req0 = 1'b1; i_wr0 = 1'b1; i_addr0 = A_EN;  i_wdata0 = 8'h09;
    i_req1 = 1'b1; i_wr1 = 1'b1; i_addr1 = A_SEL; i_wdata1 = 8'h21;
    n = 0;
    while ((ack_cnt - base) < 2 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    checks++;
    if ((ack_cnt - base) !== 2 || sb.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_acks: got %0d acks, %0d pending, required 2 and 0", ack_cnt - base, sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unmapped();
    test_round_robin();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
